// File: rtl/flash_bus_engine_pkg.sv
// Shared definitions for flash_bus_engine: opcodes, instruction field layout,
// FSM state encoding and a small elaboration helper.
package flash_ctrl_pkg;

    localparam logic [3:0] OP_NOP     = 4'd0;
    localparam logic [3:0] OP_CMD     = 4'd1;
    localparam logic [3:0] OP_ADDR    = 4'd2;
    localparam logic [3:0] OP_DIN     = 4'd3;
    localparam logic [3:0] OP_DOUT    = 4'd4;
    localparam logic [3:0] OP_WAIT_RB = 4'd5;
    localparam logic [3:0] OP_WP      = 4'd6;
    localparam logic [3:0] OP_STANDBY = 4'd7;

    localparam int OP_MSB   = 31;
    localparam int OP_LSB   = 28;
    localparam int CE_MSB   = 27;
    localparam int CE_LSB   = 24;
    localparam int BYTE_MSB = 23;
    localparam int BYTE_LSB = 16;
    localparam int CNT_MSB  = 15;
    localparam int CNT_LSB  = 0;

    typedef enum logic [3:0] {
        S_IDLE,
        S_WE_LO,
        S_WE_HI,
        S_DIN_WAIT,
        S_RE_LO,
        S_RE_HI,
        S_DOUT_WAIT,
        S_RB_WB,
        S_RB_WAIT
    } state_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/flash_bus_engine_if.sv
// Core-side FIFO port bundle of flash_bus_engine (instruction, write-data and
// read-data FIFOs). master = core/FIFO side, slave = engine.
interface flash_bus_engine_if #(
    parameter int DW = 8
);
    logic [31:0]   instruction;
    logic          iq_empty;
    logic          ack_mode_read;
    logic [DW-1:0] core_data_out;
    logic          c_data_in_rdy;
    logic          req_core_data;
    logic [DW-1:0] core_data_in;
    logic          c_data_out_rdy;
    logic          output_dval;

    // Show-ahead FIFOs: the head word is valid whenever its non-empty flag is
    // high, and an edge with ack_mode_read/req_core_data high pops it; the
    // engine only raises them while the matching FIFO reports data. A read beat
    // starts only with c_data_out_rdy high; output_dval marks each beat once.
    modport master (
        output instruction, iq_empty, core_data_out, c_data_in_rdy, c_data_out_rdy,
        input  ack_mode_read, req_core_data, core_data_in, output_dval
    );

    modport slave (
        input  instruction, iq_empty, core_data_out, c_data_in_rdy, c_data_out_rdy,
        output ack_mode_read, req_core_data, core_data_in, output_dval
    );
endinterface

// File: rtl/flash_phase_timer.sv
// Loadable down-counter timing one strobe or wait phase: load N and done is
// high during the last of the N cycles that follow.
module flash_phase_timer #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         done
);
    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val - W'(1);
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done = (cnt_q == '0);
endmodule

// File: rtl/flash_bus_engine.sv
// Micro-instruction driven NAND bus engine with NCE chip enables and
// cycle-programmable strobes. Define FLASH_RB_TIMEOUT_EN for an R/B# wait timeout.
module flash_bus_engine
    import flash_ctrl_pkg::*;
#(
    parameter int DW         = 8,
    parameter int NCE        = 4,
    parameter int T_WP       = 2,
    parameter int T_WH       = 2,
    parameter int T_RP       = 2,
    parameter int T_REH      = 2,
    parameter int T_WB       = 4,
    parameter int RB_TIMEOUT = 65535
) (
    input  logic            clk,
    input  logic            rst,
    flash_bus_engine_if.slave core,
    output logic            data_oe,
    output logic [DW-1:0]   flash_dq_o,
    input  logic [DW-1:0]   flash_dq_i,
    output logic [NCE-1:0]  oCE_N,
    output logic            oCLE,
    output logic            oALE,
    output logic            oWE_N,
    output logic            oRE_N,
    output logic            oWP_N,
    input  logic [NCE-1:0]  iRB_N,
    output logic            busy,
    output logic            err_illegal,
`ifdef FLASH_RB_TIMEOUT_EN
    output logic            err_timeout,
`endif
    output state_t          dbg_state
);
    localparam int T_MAX = max_int(max_int(max_int(T_WP, T_WH), max_int(T_RP, T_REH)), T_WB);
    localparam int TW    = $clog2(T_MAX + 1);

    state_t         state_q, state_d;
    logic [3:0]     op_q, op_d;
    logic [3:0]     ce_q, ce_d;
    logic [16:0]    beats_q, beats_d;
    logic [NCE-1:0] ce_n_q, ce_n_d;
    logic           cle_q, cle_d, ale_q, ale_d, oe_q, oe_d;
    logic           we_n_q, we_n_d, re_n_q, re_n_d, wp_n_q, wp_n_d;
    logic [DW-1:0]  dq_q, dq_d, din_q, din_d;
    logic           dval_q, dval_d, busy_q, busy_d, err_ill_q, err_ill_d;
    logic           run_q;
    logic [NCE-1:0] rb_meta_q, rb_sync_q;
    logic [15:0]    rb_ready;

    logic           tmr_load, tmr_done, finish;
    logic [TW-1:0]  tmr_val;
    logic           ack, req;
    logic [3:0]     i_op, i_ce;
    logic [7:0]     i_byte;
    logic [15:0]    i_cnt;
    logic           is_bus_op, illegal;

`ifdef FLASH_RB_TIMEOUT_EN
    localparam int TOW = $clog2(RB_TIMEOUT + 1);
    logic [TOW-1:0] tmo_q, tmo_d;
    logic           err_tmo_q, err_tmo_d;
`endif

    assign i_op      = core.instruction[OP_MSB:OP_LSB];
    assign i_ce      = core.instruction[CE_MSB:CE_LSB];
    assign i_byte    = core.instruction[BYTE_MSB:BYTE_LSB];
    assign i_cnt     = core.instruction[CNT_MSB:CNT_LSB];
    assign is_bus_op = (i_op >= OP_CMD) && (i_op <= OP_WAIT_RB);
    assign illegal   = i_op[3] || (is_bus_op && (int'(i_ce) >= NCE));
    assign rb_ready  = 16'(rb_sync_q);

    flash_phase_timer #(.W(TW)) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load),
        .load_val (tmr_val),
        .done     (tmr_done)
    );

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        ce_d      = ce_q;
        beats_d   = beats_q;
        ce_n_d    = ce_n_q;
        cle_d     = cle_q;
        ale_d     = ale_q;
        oe_d      = oe_q;
        we_n_d    = we_n_q;
        re_n_d    = re_n_q;
        wp_n_d    = wp_n_q;
        dq_d      = dq_q;
        din_d     = din_q;
        dval_d    = 1'b0;
        busy_d    = busy_q;
        err_ill_d = 1'b0;
        tmr_load  = 1'b0;
        tmr_val   = '0;
        finish    = 1'b0;
        ack       = 1'b0;
        req       = 1'b0;
`ifdef FLASH_RB_TIMEOUT_EN
        tmo_d     = tmo_q;
        err_tmo_d = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                // run_q keeps the pop low in the first cycle out of reset
                if (run_q && !core.iq_empty) begin
                    ack = 1'b1;
                    if (illegal) begin
                        err_ill_d = 1'b1;
                    end else begin
                        op_d    = i_op;
                        ce_d    = i_ce;
                        beats_d = {1'b0, i_cnt} + 17'd1;
                        if (is_bus_op) ce_n_d = ~(NCE'(1) << i_ce);
                        case (i_op)
                            OP_CMD, OP_ADDR: begin
                                state_d  = S_WE_LO;
                                cle_d    = (i_op == OP_CMD);
                                ale_d    = (i_op == OP_ADDR);
                                oe_d     = 1'b1;
                                dq_d     = DW'(i_byte);
                                we_n_d   = 1'b0;
                                tmr_load = 1'b1;
                                tmr_val  = TW'(T_WP);
                                busy_d   = 1'b1;
                            end
                            OP_DIN: begin
                                state_d = S_DIN_WAIT;
                                oe_d    = 1'b1;
                                busy_d  = 1'b1;
                            end
                            OP_DOUT: begin
                                state_d = S_DOUT_WAIT;
                                oe_d    = 1'b0;
                                busy_d  = 1'b1;
                            end
                            OP_WAIT_RB: begin
                                state_d  = S_RB_WB;
                                tmr_load = 1'b1;
                                tmr_val  = TW'(T_WB);
                                busy_d   = 1'b1;
                            end
                            OP_WP:      wp_n_d = i_byte[0];
                            OP_STANDBY: ce_n_d = '1;
                            default: ;
                        endcase
                    end
                end
            end
            S_WE_LO: begin
                if (tmr_done) begin
                    state_d  = S_WE_HI;
                    we_n_d   = 1'b1;
                    tmr_load = 1'b1;
                    tmr_val  = TW'(T_WH);
                end
            end
            S_WE_HI: begin
                if (tmr_done) begin
                    if (op_q == OP_DIN) begin
                        beats_d = beats_q - 17'd1;
                        if (beats_q == 17'd1) finish = 1'b1;
                        else state_d = S_DIN_WAIT;
                    end else begin
                        finish = 1'b1;
                    end
                end
            end
            S_DIN_WAIT: begin
                if (core.c_data_in_rdy) begin
                    req      = 1'b1;
                    dq_d     = core.core_data_out;
                    we_n_d   = 1'b0;
                    tmr_load = 1'b1;
                    tmr_val  = TW'(T_WP);
                    state_d  = S_WE_LO;
                end
            end
            S_DOUT_WAIT: begin
                if (core.c_data_out_rdy) begin
                    re_n_d   = 1'b0;
                    tmr_load = 1'b1;
                    tmr_val  = TW'(T_RP);
                    state_d  = S_RE_LO;
                end
            end
            S_RE_LO: begin
                if (tmr_done) begin
                    din_d    = flash_dq_i;
                    dval_d   = 1'b1;
                    re_n_d   = 1'b1;
                    tmr_load = 1'b1;
                    tmr_val  = TW'(T_REH);
                    state_d  = S_RE_HI;
                end
            end
            S_RE_HI: begin
                if (tmr_done) begin
                    beats_d = beats_q - 17'd1;
                    if (beats_q == 17'd1) finish = 1'b1;
                    else state_d = S_DOUT_WAIT;
                end
            end
            S_RB_WB: begin
                if (tmr_done) begin
                    state_d = S_RB_WAIT;
`ifdef FLASH_RB_TIMEOUT_EN
                    tmo_d   = '0;
`endif
                end
            end
            S_RB_WAIT: begin
                if (rb_ready[ce_q]) begin
                    finish = 1'b1;
`ifdef FLASH_RB_TIMEOUT_EN
                end else if (tmo_q == TOW'(RB_TIMEOUT - 1)) begin
                    finish    = 1'b1;
                    err_tmo_d = 1'b1;
                end else begin
                    tmo_d = tmo_q + TOW'(1);
`endif
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (finish) begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
            cle_d   = 1'b0;
            ale_d   = 1'b0;
            oe_d    = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            op_q      <= OP_NOP;
            ce_q      <= '0;
            beats_q   <= '0;
            ce_n_q    <= '1;
            cle_q     <= 1'b0;
            ale_q     <= 1'b0;
            oe_q      <= 1'b0;
            we_n_q    <= 1'b1;
            re_n_q    <= 1'b1;
            wp_n_q    <= 1'b0;
            dq_q      <= '0;
            din_q     <= '0;
            dval_q    <= 1'b0;
            busy_q    <= 1'b0;
            err_ill_q <= 1'b0;
            run_q     <= 1'b0;
            rb_meta_q <= '0;
            rb_sync_q <= '0;
`ifdef FLASH_RB_TIMEOUT_EN
            tmo_q     <= '0;
            err_tmo_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            ce_q      <= ce_d;
            beats_q   <= beats_d;
            ce_n_q    <= ce_n_d;
            cle_q     <= cle_d;
            ale_q     <= ale_d;
            oe_q      <= oe_d;
            we_n_q    <= we_n_d;
            re_n_q    <= re_n_d;
            wp_n_q    <= wp_n_d;
            dq_q      <= dq_d;
            din_q     <= din_d;
            dval_q    <= dval_d;
            busy_q    <= busy_d;
            err_ill_q <= err_ill_d;
            run_q     <= 1'b1;
            rb_meta_q <= iRB_N;
            rb_sync_q <= rb_meta_q;
`ifdef FLASH_RB_TIMEOUT_EN
            tmo_q     <= tmo_d;
            err_tmo_q <= err_tmo_d;
`endif
        end
    end

    assign core.ack_mode_read = ack;
    assign core.req_core_data = req;
    assign core.core_data_in  = din_q;
    assign core.output_dval   = dval_q;
    assign data_oe            = oe_q;
    assign flash_dq_o         = dq_q;
    assign oCE_N              = ce_n_q;
    assign oCLE               = cle_q;
    assign oALE               = ale_q;
    assign oWE_N              = we_n_q;
    assign oRE_N              = re_n_q;
    assign oWP_N              = wp_n_q;
    assign busy               = busy_q;
    assign err_illegal        = err_ill_q;
    assign dbg_state          = state_q;
`ifdef FLASH_RB_TIMEOUT_EN
    assign err_timeout        = err_tmo_q;
`endif
endmodule

// File: tb/tb_flash_bus_engine.sv
// Directed plus randomized bench for flash_bus_engine with FIFO/flash models
// and an expected-data queue.
module tb_flash_bus_engine;
    import flash_ctrl_pkg::*;

    localparam int DW  = 8;
    localparam int NCE = 4;
    localparam int T_WP = 2;

    // clock / reset
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    flash_bus_engine_if #(.DW(DW)) ifc ();
    logic           data_oe, oCLE, oALE, oWE_N, oRE_N, oWP_N, busy, err_illegal;
    logic [DW-1:0]  flash_dq_o;
    logic [DW-1:0]  flash_dq_i = '0;
    logic [NCE-1:0] oCE_N;
    logic [NCE-1:0] iRB_N;
    state_t         dbg_state;
`ifdef FLASH_RB_TIMEOUT_EN
    logic           err_timeout;
`endif

    flash_bus_engine #(
        .DW(DW), .NCE(NCE)
`ifdef FLASH_RB_TIMEOUT_EN
        , .RB_TIMEOUT(16)
`endif
    ) dut (
        .clk(clk), .rst(rst), .core(ifc.slave),
        .data_oe(data_oe), .flash_dq_o(flash_dq_o), .flash_dq_i(flash_dq_i),
        .oCE_N(oCE_N), .oCLE(oCLE), .oALE(oALE), .oWE_N(oWE_N), .oRE_N(oRE_N),
        .oWP_N(oWP_N), .iRB_N(iRB_N), .busy(busy), .err_illegal(err_illegal),
`ifdef FLASH_RB_TIMEOUT_EN
        .err_timeout(err_timeout),
`endif
        .dbg_state(dbg_state)
    );

    int checks = 0;
    int failures = 0;

    // FIFO / flash models and scoreboard
    logic [31:0]   iq[$];
    logic [DW-1:0] wq[$];
    logic [DW-1:0] fq[$];
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] we_dq[$];
    logic [DW-1:0] rd_obs[$];
    int   ack_cnt = 0, req_cnt = 0, we_cnt = 0, dval_cnt = 0, ill_cnt = 0;
    int   we_run = 0, we_len_err = 0;
    logic ack_seen = 1'b0, req_seen = 1'b0, we_prev = 1'b1, re_prev = 1'b1;

    always @(negedge clk) begin
        ack_seen = ifc.ack_mode_read;
        req_seen = ifc.req_core_data;
        if (ack_seen) ack_cnt++;
        if (req_seen) req_cnt++;
        if (oWE_N === 1'b0) begin
            if (we_prev) begin
                we_cnt++;
                we_dq.push_back(flash_dq_o);
                we_run = 0;
            end
            we_run++;
        end else if (!we_prev && rst) begin
            if (we_run != T_WP) we_len_err++;
        end
        we_prev = (oWE_N !== 1'b0);
        if (ifc.output_dval === 1'b1) begin
            dval_cnt++;
            rd_obs.push_back(ifc.core_data_in);
        end
        if (err_illegal === 1'b1) ill_cnt++;
        if (oRE_N === 1'b1 && !re_prev && fq.size() > 0) void'(fq.pop_front());
        re_prev = (oRE_N !== 1'b0);
        if (oRE_N === 1'b0 && fq.size() > 0) flash_dq_i = fq[0];
    end

    always @(posedge clk) begin
        #1;
        if (ack_seen && iq.size() > 0) void'(iq.pop_front());
        if (req_seen && wq.size() > 0) void'(wq.pop_front());
        ifc.iq_empty      = (iq.size() == 0);
        ifc.instruction   = (iq.size() > 0) ? iq[0] : 32'h0;
        ifc.c_data_in_rdy = (wq.size() > 0);
        ifc.core_data_out = (wq.size() > 0) ? wq[0] : '0;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // driver / checker tasks
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_busy(input string tag, input logic lvl, input int limit);
        int n = 0;
        while (busy !== lvl && n < limit) begin
            step();
            n++;
        end
        chk(tag, busy, lvl);
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_ce"},   oCE_N, 4'hF);
        chk({tag, "_cle"},  oCLE, 0);
        chk({tag, "_ale"},  oALE, 0);
        chk({tag, "_oe"},   data_oe, 0);
        chk({tag, "_ack"},  ifc.ack_mode_read, 0);
        chk({tag, "_req"},  ifc.req_core_data, 0);
        chk({tag, "_dval"}, ifc.output_dval, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_err"},  err_illegal, 0);
        chk({tag, "_we"},   oWE_N, 1);
        chk({tag, "_re"},   oRE_N, 1);
        chk({tag, "_wp"},   oWP_N, 0);
        chk({tag, "_dq"},   flash_dq_o, 0);
        chk({tag, "_din"},  ifc.core_data_in, 0);
    endtask

    function automatic logic [NCE-1:0] ce_sel(input int ce);
        logic [NCE-1:0] v = '1;
        v[ce] = 1'b0;
        return v;
    endfunction

    initial begin
        int n, we0, req0, dv0, ack0, ill0, idx;
        int beats, ce;
        logic ok;
        logic [NCE-1:0] ce_before;
        logic [DW-1:0]  w;

        ifc.c_data_out_rdy = 1'b1;
        iRB_N = '1;

        // reset values, with an instruction already waiting
        iq.push_back(32'h1170_0000);
        repeat (3) step();
        chk_reset("rst0");
        chk("rst0_state", dbg_state, S_IDLE);
        rst = 1'b1;

        // CMD 0x70 on ce 1
        n = 0;
        while (ifc.ack_mode_read !== 1'b1 && n < 10) begin step(); n++; end
        chk("cmd_ack", ifc.ack_mode_read, 1);
        chk("cmd_ack_busy", busy, 0);
        step();
        chk("cmd_ce", oCE_N, 4'b1101);
        chk("cmd_cle1", oCLE, 1);
        chk("cmd_we1", oWE_N, 0);
        chk("cmd_dq", flash_dq_o, 8'h70);
        chk("cmd_busy", busy, 1);
        chk("cmd_oe", data_oe, 1);
        chk("cmd_ack_once", ifc.ack_mode_read, 0);
        step();
        chk("cmd_we2", oWE_N, 0);
        chk("cmd_cle2", oCLE, 1);
        step();
        chk("cmd_we3", oWE_N, 1);
        chk("cmd_cle3", oCLE, 1);
        step();
        chk("cmd_we4", oWE_N, 1);
        chk("cmd_cle4", oCLE, 1);
        step();
        chk("cmd_done_busy", busy, 0);
        chk("cmd_done_cle", oCLE, 0);
        chk("cmd_done_oe", data_oe, 0);

        // write protect release
        iq.push_back(32'h6001_0000);
        repeat (4) step();
        chk("wp_high", oWP_N, 1);

        // DIN with underflow stall
        we0 = we_cnt; req0 = req_cnt; idx = we_dq.size();
        wq.push_back(8'h11); wq.push_back(8'h22);
        exp_q.push_back(8'h11); exp_q.push_back(8'h22);
        exp_q.push_back(8'h33); exp_q.push_back(8'h44);
        iq.push_back(32'h3100_0003);
        n = 0;
        while ((we_cnt - we0) < 2 && n < 100) begin step(); n++; end
        repeat (6) step();
        n = we_cnt;
        ok = 1'b1;
        repeat (10) begin
            step();
            if (oWE_N !== 1'b1 || data_oe !== 1'b1 || busy !== 1'b1) ok = 1'b0;
        end
        chk("din_stall_we_high", ok, 1);
        chk("din_stall_no_pulse", we_cnt, n);
        wq.push_back(8'h33); wq.push_back(8'h44);
        wait_busy("din_done", 1'b0, 200);
        chk("din_req_pulses", req_cnt - req0, 4);
        chk("din_we_pulses", we_cnt - we0, 4);
        for (int i = 0; i < 4; i++) chk("din_dq_seq", we_dq[idx + i], exp_q.pop_front());

        // DOUT with read-FIFO full stall
        dv0 = dval_cnt; idx = rd_obs.size();
        fq.push_back(8'hA5); fq.push_back(8'h5A); fq.push_back(8'hC3); fq.push_back(8'h3C);
        exp_q.push_back(8'hA5); exp_q.push_back(8'h5A);
        exp_q.push_back(8'hC3); exp_q.push_back(8'h3C);
        iq.push_back(32'h4100_0003);
        n = 0;
        while ((dval_cnt - dv0) < 2 && n < 100) begin step(); n++; end
        ifc.c_data_out_rdy = 1'b0;
        ok = 1'b1;
        repeat (5) begin
            step();
            if (oRE_N !== 1'b1 || data_oe !== 1'b0) ok = 1'b0;
        end
        chk("dout_stall_re_high", ok, 1);
        chk("dout_stall_dval", dval_cnt - dv0, 2);
        ifc.c_data_out_rdy = 1'b1;
        wait_busy("dout_done", 1'b0, 200);
        chk("dout_dval_pulses", dval_cnt - dv0, 4);
        for (int i = 0; i < 4; i++) chk("dout_data", rd_obs[idx + i], exp_q.pop_front());

        // WAIT_RB on ce 2
        iRB_N = 4'b1011;
        iq.push_back(32'h5200_0000);
        wait_busy("rb_start", 1'b1, 10);
        chk("rb_ce", oCE_N, 4'b1011);
`ifdef FLASH_RB_TIMEOUT_EN
        n = 0;
        while (err_timeout !== 1'b1 && n < 60) begin step(); n++; end
        chk("rb_timeout_pulse", err_timeout, 1);
        chk("rb_timeout_idle", busy, 0);
        step();
        chk("rb_timeout_once", err_timeout, 0);
        chk("rb_timeout_ce", oCE_N, 4'b1011);
        iRB_N = '1;
`else
        ok = 1'b1;
        repeat (20) begin
            step();
            if (busy !== 1'b1) ok = 1'b0;
        end
        chk("rb_hold_busy", ok, 1);
        iRB_N = '1;
        n = 0;
        while (busy === 1'b1 && n < 10) begin step(); n++; end
        chk("rb_release_lat", (n >= 2 && n <= 3), 1);
`endif

        // illegal opcode and ce out of range
        ack0 = ack_cnt; ill0 = ill_cnt; we0 = we_cnt; ce_before = oCE_N;
        iq.push_back(32'hF000_0000);
        iq.push_back(32'h1570_0000);
        repeat (10) step();
        chk("ill_pulses", ill_cnt - ill0, 2);
        chk("ill_acks", ack_cnt - ack0, 2);
        chk("ill_ce", oCE_N, ce_before);
        chk("ill_no_we", we_cnt - we0, 0);
        chk("ill_cle", oCLE, 0);
        chk("ill_busy", busy, 0);

        // randomized DIN / DOUT bursts
        for (int t = 0; t < 3; t++) begin
            beats = $urandom_range(1, 6);
            ce = $urandom_range(0, NCE - 1);
            we0 = we_cnt; req0 = req_cnt; idx = we_dq.size();
            for (int b = 0; b < beats; b++) begin
                w = DW'($urandom);
                wq.push_back(w);
                exp_q.push_back(w);
            end
            iq.push_back({OP_DIN, 4'(ce), 8'h00, 16'(beats - 1)});
            wait_busy("rdin_start", 1'b1, 10);
            chk("rdin_ce", oCE_N, ce_sel(ce));
            wait_busy("rdin_done", 1'b0, 300);
            chk("rdin_we_pulses", we_cnt - we0, beats);
            chk("rdin_req_pulses", req_cnt - req0, beats);
            for (int b = 0; b < beats; b++) chk("rdin_dq", we_dq[idx + b], exp_q.pop_front());

            beats = $urandom_range(1, 6);
            ce = $urandom_range(0, NCE - 1);
            dv0 = dval_cnt; idx = rd_obs.size();
            for (int b = 0; b < beats; b++) begin
                w = DW'($urandom);
                fq.push_back(w);
                exp_q.push_back(w);
            end
            iq.push_back({OP_DOUT, 4'(ce), 8'h00, 16'(beats - 1)});
            n = 0;
            while ((busy !== 1'b1 || (dval_cnt - dv0) < beats) && n < 400) begin
                step();
                ifc.c_data_out_rdy = 1'($urandom_range(0, 1));
                n++;
            end
            ifc.c_data_out_rdy = 1'b1;
            wait_busy("rdout_done", 1'b0, 100);
            chk("rdout_ce", oCE_N, ce_sel(ce));
            chk("rdout_dval_pulses", dval_cnt - dv0, beats);
            for (int b = 0; b < beats; b++) chk("rdout_data", rd_obs[idx + b], exp_q.pop_front());
        end
        chk("we_low_len_errors", we_len_err, 0);

        // reset in the middle of DIN beat 2
        we0 = we_cnt;
        wq.push_back(8'h5C); wq.push_back(8'hC5);
        iq.push_back(32'h3000_0003);
        n = 0;
        while (!((we_cnt - we0) == 2 && oWE_N === 1'b0) && n < 100) begin step(); n++; end
        chk("mid_din_reached", oWE_N, 0);
        rst = 1'b0;
        #1;
        chk_reset("rst_mid");
        req0 = req_cnt;
        wq.push_back(8'h77); wq.push_back(8'h88);
        repeat (3) step();
        rst = 1'b1;
        repeat (6) step();
        chk("rst_no_req", req_cnt - req0, 0);
        chk("rst_idle_busy", busy, 0);
        chk("rst_idle_we", oWE_N, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/flash_bus_engine.md
Name: flash_bus_engine

Overview:
- Parametrised successor of the single-chip NAND bus controller.
- Executes 32-bit micro-instructions popped from a show-ahead instruction FIFO: command, address, data-in, data-out, ready/busy wait, write protect, standby.
- Drives an async-timed NAND bus across NCE chip enables with configurable data width and cycle-programmable strobe timing.
- Sits between the core FIFOs and the top-level tristate pad wrapper.

Parameters:
DW, 8, flash data bus width (8 or 16); cmd/addr bytes use dq[7:0], upper bits 0
NCE, 4, number of chip enables / R/B# lines (1..16)
T_WP, 2, WE_N low cycles (>=1)
T_WH, 2, WE_N high cycles (>=1)
T_RP, 2, RE_N low cycles (>=1)
T_REH, 2, RE_N high cycles (>=1)
T_WB, 4, cycles ignored after WAIT_RB entry before sampling R/B#
RB_TIMEOUT, 65535, WAIT_RB limit in cycles (used only with macro)

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active low
instruction  in  32  head of instruction FIFO: [31:28] op, [27:24] ce, [23:16] byte, [15:0] count (beats-1)
iq_empty  in  1  instruction FIFO empty
ack_mode_read  out  1  one-cycle pop of instruction FIFO
core_data_out  in  DW  head of write-data FIFO (show-ahead)
c_data_in_rdy  in  1  write-data FIFO non-empty
req_core_data  out  1  one-cycle pop of write-data FIFO
core_data_in  out  DW  read data to core
c_data_out_rdy  in  1  read-data FIFO has space
output_dval  out  1  core_data_in valid, one cycle per beat
data_oe  out  1  pad output enable
flash_dq_o  out  DW  pad output data
flash_dq_i  in  DW  pad input data
oCE_N  out  NCE  chip enables
oCLE, oALE  out  1  command/address latch enables
oWE_N, oRE_N  out  1  write/read strobes
oWP_N  out  1  write protect
iRB_N  in  NCE  ready/busy, async
busy  out  1  instruction in progress
err_illegal  out  1  one-cycle pulse on illegal instruction

Behaviour:
- Reset values: oCE_N all 1; oCLE, oALE, data_oe, ack, req, dval, busy, err 0; oWE_N, oRE_N 1; oWP_N 0; dq_o, core_data_in 0. Reset mid-operation aborts immediately; no partial strobe survives.
- Ops:
  - 0 NOP
  - 1 CMD
  - 2 ADDR
  - 3 DIN
  - 4 DOUT
  - 5 WAIT_RB
  - 6 WP (oWP_N <= byte[0])
  - 7 STANDBY (oCE_N all 1)
  - 8-15 illegal
- FSM states: IDLE, WE_LO, WE_HI, DIN_WAIT, RE_LO, RE_HI, DOUT_WAIT, RB_WB, RB_WAIT.
- IDLE with !iq_empty:
  - ack_mode_read=1 that cycle; fields latch at the edge.
  - busy rises next cycle and stays high until return to IDLE.
  - Next instruction is not acked in the same cycle as the return.
- CE select: for ops 1-5, oCE_N[ce] goes low at latch and all others go high; selection persists after the op until STANDBY or another ce. ce>=NCE on ops 1-5: illegal.
- Illegal instruction: err_illegal pulses the cycle after ack; instruction is consumed; bus outputs unchanged.
- CMD/ADDR:
  - oCLE/oALE=1, data_oe=1, dq_o=byte, held through WE_LO (T_WP cycles) and WE_HI (T_WH cycles).
  - Deasserted on return to IDLE.
  - Occupancy: 1+T_WP+T_WH cycles from ack.
  - count is ignored.
- DIN: count+1 beats. Each beat:
  - If c_data_in_rdy: req_core_data=1 and dq_o<=core_data_out in the same cycle, then WE_LO and WE_HI.
  - Otherwise: stay in DIN_WAIT with oWE_N=1 (underflow stall, no glitch).
  - data_oe=1 for the whole op.
- DOUT: count+1 beats, data_oe=0. Each beat:
  - Requires c_data_out_rdy, else wait in DOUT_WAIT with oRE_N=1.
  - RE_LO lasts T_RP cycles; at the edge ending the last RE_LO cycle, core_data_in<=flash_dq_i, and output_dval=1 during the first RE_HI cycle.
  - RE_HI lasts T_REH cycles.
- WAIT_RB:
  - RB_WB for T_WB cycles, then RB_WAIT until the synchronised iRB_N[ce]=1.
  - iRB_N uses a 2-flop synchroniser per line.
- Count of 0xFFFF is 65536 beats; the 17-bit beat counter does not wrap.

Optional Feature:
- Macro FLASH_RB_TIMEOUT_EN.
- When defined:
  - Adds output err_timeout (1 bit, reset 0).
  - RB_WAIT counts cycles; after RB_TIMEOUT cycles without ready, err_timeout pulses one cycle and the FSM returns to IDLE (instruction completed, CE unchanged).
- When undefined: the port and counter are absent and RB_WAIT waits indefinitely.

Decomposition:
- Package flash_ctrl_pkg: opcode localparams, instruction field bit positions, FSM state encoding.
- One sub-module, flash_phase_timer: loadable down-counter (width $clog2 of the max T_* + 1), load/done interface; shared by WE, RE and WB phases.

Test Plan:
- Defaults; instruction 0x1170_0000 -> ack one cycle; oCE_N=4'b1101; oCLE=1 for 4 cycles; oWE_N low exactly 2 cycles; dq_o=0x70; busy low on cycle 6.
- DIN count=3; FIFO holds 2 words (0x11,0x22), 2 more supplied 10 cycles later -> 4 req pulses, 4 WE pulses; oWE_N=1 throughout the stall; dq_o sequence 11,22,33,44.
- DOUT count=3; flash_dq_i=A5,5A,C3,3C; c_data_out_rdy low for 5 cycles after beat 2 -> 4 output_dval pulses with matching data; oRE_N high during the stall.
- WAIT_RB on ce=2 with iRB_N[2] low for 20 cycles -> busy until 2-3 cycles after release. With FLASH_RB_TIMEOUT_EN and RB_TIMEOUT=16, iRB_N stuck low -> err_timeout pulse, return to IDLE.
- Instruction 0xF000_0000, then CMD with ce=5 -> two err_illegal pulses, two acks, bus unchanged.
- rst low mid-DIN beat 2 -> all outputs at reset values within the same cycle; no further req_core_data.
